regfile_mp: RTL

Parametrised multi-port integer register file with a per-register busy scoreboard, the successor to the single-write, two-read register file in the core's decode/writeback path. It serves NREAD combinational read ports and NWRITE registered write ports, hardwires x0 to zero, and resolves same-cycle write conflicts deterministically. It tracks in-flight producers through issue/writeback busy bits so that decode can stall on RAW hazards without a separate scoreboard.

---
 rtl/common.sv | 11 +
 rtl/regfile_scoreboard.sv | 38 +++
 rtl/regfile_mp.sv | 88 ++++++++
 3 files changed

// File: rtl/common.sv
// Shared core types and register-file sizing constants.
package common;

    localparam int REGFILE_NREG_DEFAULT = 32;
    localparam int REGFILE_MAX_READ     = 4;
    localparam int REGFILE_MAX_WRITE    = 2;

    typedef logic [63:0] u64;
    typedef logic [$clog2(REGFILE_NREG_DEFAULT)-1:0] creg_addr_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits: set on issue, cleared on writeback, wiped by flush.
module regfile_scoreboard
    import common::*;
#(
    parameter int NREG = REGFILE_NREG_DEFAULT,
    parameter int AW   = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            issue,
    input  logic [AW-1:0]   issue_rd,
    input  logic [NREG-1:0] wb_clr,
    input  logic            flush,
    output logic [NREG-1:0] busy
);

    logic [NREG-1:0] busy_next;

    // Set is applied after clear so a new producer supersedes the retiring one.
    always_comb begin
        busy_next = busy & ~wb_clr;
        if (issue && issue_rd != '0) begin
            busy_next[issue_rd] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy <= '0;
        end else if (flush) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port 64-bit register file with x0 hardwired to zero and a RAW busy scoreboard.
// Define REGFILE_BYPASS_EN for same-cycle write-to-read forwarding.
module regfile_mp
    import common::*;
#(
    parameter int NREAD  = 2,
    parameter int NWRITE = 1,
    parameter int NREG   = REGFILE_NREG_DEFAULT,
    parameter int AW     = $clog2(NREG)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NREAD-1:0][AW-1:0]    ra,
    output u64   [NREAD-1:0]            rd,
    output logic [NREAD-1:0]            rbusy,
    input  logic [NWRITE-1:0]           wvalid,
    input  logic [NWRITE-1:0][AW-1:0]   wa,
    input  u64   [NWRITE-1:0]           wd,
    input  logic                        iss_valid,
    input  logic [AW-1:0]               iss_rd,
    input  logic                        flush,
    output logic                        busy_any
);

    // wvalid and iss_valid are single-cycle qualifiers with no ready: whatever
    // is presented before an edge commits at that edge, there is no stalling.

    u64              regs [NREG];
    logic [NREG-1:0] busy;
    logic [NREG-1:0] wb_clr;
    logic [NWRITE-1:0] wq;

    always_comb begin
        wb_clr = '0;
        for (int i = 0; i < NWRITE; i++) begin
            wq[i] = wvalid[i] && (wa[i] != '0);
            if (wq[i]) begin
                wb_clr[wa[i]] = 1'b1;
            end
        end
    end

    // Later ports are assigned last, so the highest qualified index wins a conflict.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NREG; k++) begin
                regs[k] <= '0;
            end
        end else begin
            for (int i = 0; i < NWRITE; i++) begin
                if (wq[i]) begin
                    regs[wa[i]] <= wd[i];
                end
            end
        end
    end

    regfile_scoreboard #(
        .NREG (NREG),
        .AW   (AW)
    ) u_scoreboard (
        .clk      (clk),
        .reset    (reset),
        .issue    (iss_valid),
        .issue_rd (iss_rd),
        .wb_clr   (wb_clr),
        .flush    (flush),
        .busy     (busy)
    );

    always_comb begin
        for (int j = 0; j < NREAD; j++) begin
            rd[j]    = (ra[j] == '0) ? '0 : regs[ra[j]];
            rbusy[j] = busy[ra[j]];
`ifdef REGFILE_BYPASS_EN
            for (int i = 0; i < NWRITE; i++) begin
                if (wq[i] && wa[i] == ra[j]) begin
                    rd[j]    = wd[i];
                    rbusy[j] = busy[ra[j]] && iss_valid && (iss_rd == ra[j]);
                end
            end
`endif
        end
    end

    assign busy_any = |busy;

endmodule
